// File: rtl/apb_timer.sv
// rtl/apb_timer.sv - APB timer: 32-bit prescaled up-counter with compare match and level irq
module apb_timer #(
    parameter int PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        psel,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        irq
);

    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_PRESCALE = 3'd1;
    localparam logic [2:0] A_COMPARE  = 3'd2;
    localparam logic [2:0] A_COUNT    = 3'd3;
    localparam logic [2:0] A_STATUS   = 3'd4;

    logic [2:0]            ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [31:0]           compare_q, compare_d;
    logic [31:0]           count_q, count_d;
    logic                  match_q, match_d;

    logic       wr_en;
    logic       cnt_wr;
    logic       tick;
    logic       hit;
    logic [2:0] addr;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^{PADDR[31:5], PADDR[1:0]};
    assign irq = match_q & ctrl_q[2];

    always_comb begin
        addr       = PADDR[4:2];
        wr_en      = psel & PENABLE & PWRITE;
        cnt_wr     = wr_en && (addr == A_COUNT);
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        count_d    = count_q;
        match_d    = match_q;

        tick = ctrl_q[0] && (pcnt_q == prescale_q);
        // A bus load of COUNT on a tick edge suppresses the match evaluation entirely.
        hit  = tick && !cnt_wr && (count_q == compare_q);

        if (!ctrl_q[0] || tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PRESCALE_W'(1);
        end

        if (tick && !cnt_wr) begin
            if (hit) begin
                if (ctrl_q[1]) begin
                    count_d = '0;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        if (wr_en) begin
            case (addr)
                A_CTRL: begin
                    ctrl_d = PWDATA[2:0];
                    pcnt_d = '0;
                end
                A_PRESCALE: begin
                    prescale_d = PWDATA[PRESCALE_W-1:0];
                    pcnt_d     = '0;
                end
                A_COMPARE: compare_d = PWDATA;
                A_COUNT:   count_d   = PWDATA;
                A_STATUS:  if (PWDATA[0]) match_d = 1'b0;
                default: ;
            endcase
        end

        if (hit) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            compare_q  <= '0;
            count_q    <= '0;
            match_q    <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            compare_q  <= compare_d;
            count_q    <= count_d;
            match_q    <= match_d;
        end
    end

    always_comb begin
        PRDATA = '0;
        if (psel && !PWRITE) begin
            case (addr)
                A_CTRL:     PRDATA = {29'd0, ctrl_q};
                A_PRESCALE: PRDATA = 32'(prescale_q);
                A_COMPARE:  PRDATA = compare_q;
                A_COUNT:    PRDATA = count_q;
                A_STATUS:   PRDATA = {31'd0, match_q};
                default:    PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_timer.sv
// tb/tb_apb_timer.sv - directed and randomized checks of apb_timer against a behavioural model
module tb_apb_timer;

    localparam int PW = 16;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        psel = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        irq;

    int total = 0;
    int bad = 0;

    apb_timer #(.PRESCALE_W(PW)) dut (
        .clk(clk), .n_rst(n_rst), .psel(psel), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference state, advanced once per rising edge from the register-map rules.
    logic [2:0]  m_ctrl;
    logic [31:0] m_pre, m_cmp, m_cnt, m_pcnt;
    logic        m_match;

    always @(posedge clk) begin
        logic        wr, tick, cnt_loaded, new_match;
        logic [2:0]  a;
        logic [2:0]  n_ctrl;
        logic [31:0] n_pcnt, n_cnt;
        wr = psel && PENABLE && PWRITE;
        a = PADDR[4:2];
        if (!n_rst) begin
            m_ctrl = 0; m_pre = 0; m_cmp = 0; m_cnt = 0; m_pcnt = 0; m_match = 0;
        end else begin
            n_ctrl = m_ctrl; n_cnt = m_cnt; new_match = 0;
            tick = 0;
            if (m_ctrl[0] == 1'b0) n_pcnt = 0;
            else if (m_pcnt == m_pre) begin tick = 1; n_pcnt = 0; end
            else n_pcnt = m_pcnt + 1;
            cnt_loaded = wr && a == 3;
            if (tick && !cnt_loaded) begin
                if (m_cnt == m_cmp) begin
                    new_match = 1;
                    if (m_ctrl[1]) n_cnt = 0; else n_ctrl[0] = 0;
                end else n_cnt = m_cnt + 1;
            end
            if (wr && a == 0) begin n_ctrl = PWDATA[2:0]; n_pcnt = 0; end
            if (wr && a == 1) begin m_pre = PWDATA & ((32'd1 << PW) - 1); n_pcnt = 0; end
            if (wr && a == 2) m_cmp = PWDATA;
            if (wr && a == 3) n_cnt = PWDATA;
            if (wr && a == 4 && PWDATA[0]) m_match = 0;
            if (new_match) m_match = 1;
            m_ctrl = n_ctrl; m_cnt = n_cnt; m_pcnt = n_pcnt;
        end
    end

    function automatic logic [31:0] mread(input logic [2:0] a);
        case (a)
            3'd0: return {29'd0, m_ctrl};
            3'd1: return m_pre;
            3'd2: return m_cmp;
            3'd3: return m_cnt;
            3'd4: return {31'd0, m_match};
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        psel = 1; PENABLE = 0; PWRITE = 1; PADDR = {27'd0, a, 2'b00}; PWDATA = d;
        @(negedge clk); PENABLE = 1;
        @(negedge clk); psel = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        psel = 1; PENABLE = 0; PWRITE = 0; PADDR = {27'd0, a, 2'b00};
        #1;
        d = PRDATA;
        check("rd_model", d, mread(a));
        check("irq_model", {31'd0, irq}, {31'd0, m_match & m_ctrl[2]});
        @(negedge clk); PENABLE = 1;
        @(negedge clk); psel = 0; PENABLE = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic stop_clear();
        wr(3'd0, 32'd0);
        wr(3'd4, 32'd1);
        wr(3'd3, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] pre_seq [8];
        logic [31:0] ar_seq [6];
        pre_seq = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2};
        ar_seq  = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd0};

        idle(3);
        n_rst = 1;
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_prdata_idle", PRDATA, 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), d);
            check("rst_read", d, 32'd0);
        end

        wr(3'd0, 32'h7); wr(3'd1, 32'h3); wr(3'd2, 32'h10);
        rd(3'd0, d); check("rb_ctrl", d, 32'h7);
        rd(3'd1, d); check("rb_pre", d, 32'h3);
        rd(3'd2, d); check("rb_cmp", d, 32'h10);
        wr(3'd6, 32'hDEADBEEF);
        rd(3'd6, d); check("rb_0x18", d, 32'd0);

        // Prescale 3: COUNT steps every 4 edges after EN.
        stop_clear();
        wr(3'd1, 32'd3); wr(3'd2, 32'hFFFFFFFF); wr(3'd0, 32'h1);
        psel = 1; PWRITE = 0; PADDR = 32'h0C;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("pre_seq", PRDATA, pre_seq[i]);
            check("pre_model", PRDATA, m_cnt);
        end
        psel = 0;
        wr(3'd0, 32'h0);
        idle(8);
        rd(3'd3, d); check("pre_frozen", d, 32'd2);

        // One-shot at COMPARE=5.
        stop_clear();
        wr(3'd1, 32'd0); wr(3'd2, 32'd5); wr(3'd0, 32'h5);
        idle(5);
        check("os_irq_pre", {31'd0, irq}, 32'd0);
        idle(1);
        check("os_irq", {31'd0, irq}, 32'd1);
        rd(3'd4, d); check("os_match", d, 32'd1);
        rd(3'd3, d); check("os_count", d, 32'd5);
        rd(3'd0, d); check("os_ctrl", d, 32'h4);
        wr(3'd4, 32'd1);
        check("os_irq_clr", {31'd0, irq}, 32'd0);

        // Auto-reload, period 6, W1C colliding with a match edge.
        stop_clear();
        wr(3'd1, 32'd1); wr(3'd2, 32'd2); wr(3'd0, 32'h3);
        psel = 1; PWRITE = 0; PADDR = 32'h0C;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("ar_seq", PRDATA, ar_seq[i]);
        end
        psel = 0;
        wr(3'd4, 32'd1);
        rd(3'd4, d); check("ar_cleared", d, 32'd0);
        wr(3'd4, 32'd1);
        rd(3'd4, d); check("ar_set_wins", d, 32'd1);

        // Wrap without match, then match on the following tick.
        stop_clear();
        wr(3'd1, 32'd0); wr(3'd2, 32'd0); wr(3'd3, 32'hFFFFFFFF); wr(3'd0, 32'h5);
        psel = 1; PWRITE = 0; PADDR = 32'h0C;
        @(negedge clk);
        check("wrap_count", PRDATA, 32'd0);
        check("wrap_nomatch", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("wrap_hold", PRDATA, 32'd0);
        check("wrap_match", {31'd0, irq}, 32'd1);
        psel = 0;

        // COUNT write on a tick edge wins.
        stop_clear();
        wr(3'd1, 32'd0); wr(3'd2, 32'hFFFFFFFF); wr(3'd0, 32'h1);
        idle(3);
        wr(3'd3, 32'h100);
        rd(3'd3, d); check("coll_count", d, 32'h100);

        // Reset mid-count with irq high.
        stop_clear();
        wr(3'd1, 32'd0); wr(3'd2, 32'd0); wr(3'd0, 32'h7);
        wr(3'd1, 32'hFFFF); wr(3'd3, 32'h20);
        check("mrst_irq_pre", {31'd0, irq}, 32'd1);
        n_rst = 0;
        @(negedge clk);
        n_rst = 1;
        check("mrst_irq", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            rd(3'(i), d);
            check("mrst_reg", d, 32'd0);
        end
        idle(20);
        rd(3'd3, d); check("mrst_no_count", d, 32'd0);

        // Randomized traffic checked against the model.
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [2:0] a;
            logic [31:0] v;
            r = $urandom_range(0, 9);
            a = 3'($urandom_range(0, 7));
            if (r <= 3) begin
                case (a)
                    3'd0: v = $urandom & 32'h7;
                    3'd1: v = $urandom_range(0, 3);
                    3'd2: v = $urandom_range(0, 12);
                    3'd3: v = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFF : $urandom_range(0, 12);
                    3'd4: v = $urandom & 32'h1;
                    default: v = $urandom;
                endcase
                wr(a, v);
            end else if (r <= 6) begin
                rd(a, d);
            end else begin
                idle($urandom_range(1, 4));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_timer.md
# apb_timer

APB slave timer peripheral, downstream of the AHB-to-APB bridge. It receives the bridge's decoded select, PENABLE, PWRITE, PADDR and PWDATA, and returns PRDATA. It provides a 32-bit up-counter with a programmable prescaler, a compare match and a level interrupt. The bridge has no wait-state input, so every access completes in the bridge's two-cycle setup/enable sequence.

## Interface
Parameters:
- PRESCALE_W, default 16: width of the PRESCALE register and of the internal prescale counter.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset: one clock; reset is synchronous and active-low.
- psel  in  1  slave select, the bridge's psel_en after address decode.
- PENABLE  in  1  APB enable phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  byte address; only PADDR[4:2] is decoded.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- irq  out  1  level interrupt, equal to MATCH & IRQ_EN.

## Operation
Register map, selected by PADDR[4:2]. Unused bits read 0.
- 0x00 CTRL, R/W: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN.
- 0x04 PRESCALE, R/W, [PRESCALE_W-1:0].
- 0x08 COMPARE, R/W, [31:0].
- 0x0C COUNT, R/W; a write loads the counter.
- 0x10 STATUS: bit0 MATCH, write-1-to-clear.
- 0x14–0x1C: read 0; writes ignored.

APB access:
- Write strobe is psel & PENABLE & PWRITE. The register updates on that clock edge. The setup phase has no side effects.
- PRDATA is combinational. It is the addressed register when psel & !PWRITE, otherwise 0. It is valid in both setup and enable phases.
- Reads have no side effects.

Counting:
- Internal pcnt, PRESCALE_W bits, not visible on the bus.
- On each edge with EN=1:
  - If pcnt == PRESCALE: tick, and pcnt <= 0.
  - Otherwise pcnt <= pcnt + 1.
- On each tick:
  - If COUNT == COMPARE: MATCH <= 1. With AUTO_RELOAD=1, COUNT <= 0. With AUTO_RELOAD=0, COUNT holds and EN <= 0 (one-shot).
  - Otherwise COUNT <= COUNT + 1, mod 2^32. 0xFFFFFFFF wraps to 0 with no flag.
- EN=0: pcnt is held at 0 and COUNT holds.

Arithmetic: all counters are unsigned. PRESCALE=0 gives one tick per cycle.

Boundary and simultaneous events:
- APB write to COUNT in the same cycle as a tick: the written value wins. No match is evaluated that cycle.
- Write to PRESCALE or CTRL: pcnt <= 0 on the same edge.
- A write to CTRL takes precedence over the one-shot EN clear in the same cycle.
- STATUS W1C in the same cycle as a new match: MATCH stays 1 (set wins).
- COMPARE=0 with AUTO_RELOAD=1: MATCH on every tick; COUNT stays 0.
- Reset (n_rst=0 at an edge), including mid-count: CTRL, PRESCALE, COMPARE, COUNT, MATCH and pcnt all go to 0. No write is accepted on that edge.

## Timing
Reset values: PRDATA=0 (psel low), irq=0. All registers are 0.

Write latency:
- The new value is visible on the edge that ends the enable phase.
- A read in the next access returns it.

Count latency:
- EN is written at edge k. The first tick occurs at edge k+PRESCALE+1, so COUNT=1 after that edge (starting from 0).
- Auto-reload period: (COMPARE+1)*(PRESCALE+1) cycles between MATCH assertions.
- MATCH and irq assert on the tick edge where COUNT == COMPARE. irq has no extra delay beyond that register.

irq is a level output. It stays high until MATCH is cleared or IRQ_EN is cleared, and drops on that write edge.

## Test plan
- Reset/readback: after reset, read all 8 offsets → 0. Write CTRL=0x7, PRESCALE=0x3, COMPARE=0x10, then read back → 0x7, 0x3, 0x10. Write 0x18 → ignored, reads 0.
- Prescale: PRESCALE=3, COMPARE=0xFFFFFFFF, EN=1 written at edge k → COUNT=1 at k+4, COUNT=2 at k+8. Clear EN → COUNT frozen.
- One-shot: PRESCALE=0, COMPARE=5, CTRL=0x5 → MATCH and irq at edge k+6, COUNT stays 5, CTRL reads 0x4. Write STATUS=1 → irq falls on that edge.
- Auto-reload: PRESCALE=1, COMPARE=2, CTRL=0x3 → MATCH every 6 cycles; COUNT sequence 1,2,0. A W1C issued on a match edge leaves MATCH=1.
- Wrap/collision: load COUNT=0xFFFFFFFF, COMPARE=0, PRESCALE=0, EN=1 → COUNT=0 with no MATCH, then MATCH on the next tick. A COUNT write of 0x100 on a tick edge → reads 0x100.
- Reset mid-count: pull n_rst low for one edge while COUNT=0x20 and irq=1 → all registers 0, irq=0, and counting does not resume.
